// File: rtl/uart_cfg_pkg.sv
// uart_cfg_pkg: shared FSM states, line-format encodings and data-width limits
// for the configurable UART transmitter.
package uart_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_ODD   = 2'b10;
  localparam logic [1:0] PAR_NONE2 = 2'b11;

  localparam logic [1:0] STOP_1    = 2'b00;
  localparam logic [1:0] STOP_1H   = 2'b01;
  localparam logic [1:0] STOP_2    = 2'b10;
  localparam logic [1:0] STOP_2B   = 2'b11;

  localparam logic [3:0] DBITS_MIN    = 4'd5;
  localparam int         DBIT_MAX_DEF = 9;

  function automatic logic [3:0] clamp_dbits(
    input logic [3:0] d,
    input logic [3:0] dmax
  );
    logic [3:0] r;
    r = d;
    if (d < DBITS_MIN)
      r = DBITS_MIN;
    else if (d > dmax)
      r = dmax;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with per-frame data width, parity and stop length.
// Parity generation exists only when UART_TX_CFG_PARITY_EN is defined.
module uart_tx_cfg
  import uart_cfg_pkg::*;
#(
  parameter int DBIT_MAX = DBIT_MAX_DEF,
  parameter int OVS      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_tick,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic [DBIT_MAX-1:0] din,
  input  logic [3:0]          dbits,
  input  logic [1:0]          parity_mode,
  input  logic [1:0]          stop_mode,
  output logic                busy,
  output logic                tx_done_tick,
  output logic                tx
);

  localparam int            TW       = $clog2(2 * OVS);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [TW-1:0] LAST_BIT = TW'(OVS - 1);
  localparam logic [TW-1:0] LAST_1H  = TW'((3 * OVS) / 2 - 1);
  localparam logic [TW-1:0] LAST_2   = TW'(2 * OVS - 1);

  state_t              state_q, state_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [3:0]          bit_q, bit_d;
  logic [DBIT_MAX-1:0] shreg_q, shreg_d;
  logic [3:0]          nbits_q;
  logic [3:0]          nb_in;
  logic [1:0]          stop_q;
  logic [TW-1:0]       stop_last;
  logic                tx_q, tx_d;
  logic                accept;
  logic                tick_end;
  logic                done;

`ifdef UART_TX_CFG_PARITY_EN
  logic pen_q, par_q;
  logic pen_in, par_in;
`else
  logic unused_par;
  assign unused_par = ^parity_mode;
`endif

  assign nb_in  = clamp_dbits(dbits, 4'(DBIT_MAX));
  assign accept = (state_q == IDLE) && tx_valid;

`ifdef UART_TX_CFG_PARITY_EN
  assign pen_in = (parity_mode == PAR_EVEN) ||
                  (parity_mode == PAR_ODD);

  // Odd parity seeds the XOR with 1; bits above the clamped width are masked.
  always_comb begin
    par_in = (parity_mode == PAR_ODD);
    for (int i = 0; i < DBIT_MAX; i++)
      if (i < int'(nb_in))
        par_in = par_in ^ din[i];
  end
`endif

  always_comb begin
    stop_last = LAST_BIT;
    unique case (1'b1)
      stop_q == STOP_1H: stop_last = LAST_1H;
      stop_q[1]:         stop_last = LAST_2;
      default:           stop_last = LAST_BIT;
    endcase
  end

  assign tick_end = s_tick &&
    (tick_q == ((state_q == STOP) ? stop_last : LAST_BIT));

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done    = 1'b0;
    if (s_tick && state_q != IDLE)
      tick_d = tick_end ? '0 : tick_q + T_ONE;
    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d = START;
          tick_d  = '0;
          bit_d   = '0;
          shreg_d = din;
        end
      end
      START: begin
        if (tick_end)
          state_d = DATA;
      end
      DATA: begin
        if (tick_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == nbits_q - 4'd1) begin
            bit_d = '0;
`ifdef UART_TX_CFG_PARITY_EN
            state_d = pen_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
`ifdef UART_TX_CFG_PARITY_EN
      PARITY: begin
        if (tick_end)
          state_d = STOP;
      end
`endif
      STOP: begin
        if (tick_end) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_q[0];
`ifdef UART_TX_CFG_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      nbits_q <= '0;
      stop_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      if (accept) begin
        nbits_q <= nb_in;
        stop_q  <= stop_mode;
      end
    end
  end

`ifdef UART_TX_CFG_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pen_q <= 1'b0;
      par_q <= 1'b0;
    end else if (accept) begin
      pen_q <= pen_in;
      par_q <= par_in;
    end
  end
`endif

  assign tx_ready     = (state_q == IDLE);
  assign busy         = ~tx_ready;
  assign tx_done_tick = done;
  assign tx           = tx_q;

endmodule
